// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host FSM states and keyboard command bytes.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE, ERR} state_t;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser per lane with a gated falling-edge pulse on lane 0.
module ps2_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         fall
);
    logic [W-1:0] meta;
    logic         prev;
    // lines idle high, so reset to the idle level to avoid a spurious edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
            prev <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q[0];
        end
    end
    assign fall = en & prev & ~q[0];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter -- request-to-send, LSB-first byte with odd parity, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_cnt, bit_n;
    logic [8:0]       shreg, sh_n;
    logic             c_n, d_n, done_n, err_n, abort;
    logic [1:0]       sq;
    logic             fall;

    // lane 0 is the clock (edge-detected), lane 1 the data (synchronised only)
    ps2_sync_edge #(.W(2)) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      ({ps2d_in, ps2c_in}),
        .en     (state != INHIBIT),
        .q      (sq),
        .fall   (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            ps2c_oe <= c_n;
            ps2d_oe <= d_n;
            tx_done <= done_n;
            tx_err  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        bit_n   = bit_cnt;
        sh_n    = shreg;
        c_n     = 1'b0;
        d_n     = ps2d_oe;
        done_n  = 1'b0;
        err_n   = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_start) begin
                    state_n = INHIBIT;
                    c_n     = 1'b1;
                    bit_n   = '0;
                    sh_n    = {~^tx_data, tx_data};
                end
            end
            INHIBIT: begin
                // data goes low one cycle before the clock is released
                c_n = ~ps2d_oe;
                d_n = ps2d_oe | (cnt == INH_LAST);
                if (ps2d_oe) begin
                    state_n = SEND;
                    cnt_n   = '0;
                end
            end
            SEND: begin
                abort = cnt == TO_LAST;
                if (fall) begin
                    bit_n   = bit_cnt + 4'd1;
                    d_n     = ~shreg[0];
                    sh_n    = {1'b1, shreg[8:1]};
                    state_n = (bit_cnt == 4'd9) ? ACK : SEND;
                end
            end
            ACK: begin
                abort = (cnt == TO_LAST) | (fall & sq[1]);
                if (fall) state_n = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                abort  = ~tx_done & (cnt == TO_LAST);
                done_n = ~tx_done & sq[0] & sq[1];
                if (tx_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // timeout or NACK overrides any edge seen in the same cycle
        if (abort) begin
            state_n = ERR;
            d_n     = 1'b0;
            done_n  = 1'b0;
            err_n   = 1'b1;
        end
    end

    assign tx_busy = state != IDLE;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed PS/2 frames against an open-drain device model, with a per-cycle handshake model.
module tb_ps2_host_tx;
    localparam int I = 20;
    localparam int T = 2000;
    localparam int H = 20;

    logic        clk = 1'b0;
    logic        reset_n, tx_start, ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err;
    logic [7:0]  tx_data;
    logic        dev_c = 1'b1, dev_d = 1'b1;
    logic        ps2c_in, ps2d_in;
    logic [10:0] got;
    int          total = 0, bad = 0, n_done = 0, n_err = 0, since = 0;
    bit          m_busy = 1'b0, prev_pulse = 1'b0;

    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;
    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(I), .TIMEOUT_CYCLES(T), .CNT_W(21)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx_err  (tx_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // busy spans accept+1 .. pulse+1, clock held low for I+1 cycles, data low from cycle I
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            m_busy = 1'b0;
            prev_pulse = 1'b0;
            check("rst_outputs", {tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe}, 0);
        end else begin
            if (!m_busy) begin
                m_busy = tx_start;
                since = 0;
            end else if (prev_pulse) m_busy = 1'b0;
            else since++;
            check("busy", tx_busy, m_busy);
            check("one_pulse", tx_done & tx_err, 0);
            if (!m_busy || tx_done || tx_err) check("pins_released", {ps2c_oe, ps2d_oe}, 0);
            else if (since <= I) check("inhibit_pins", {ps2c_oe, ps2d_oe}, {1'b1, since == I});
            else check("clk_released", ps2c_oe, 0);
            if (!m_busy) check("stray_pulse", tx_done | tx_err, 0);
            prev_pulse = tx_done | tx_err;
            n_done += int'(tx_done);
            n_err += int'(tx_err);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", tx_busy, 0);
    endtask

    task automatic device(input logic [7:0] b, input int edges, input bit ack_low, input int rst_fall,
                          output logic [10:0] f);
        logic [10:0] exp_f;
        int n;
        exp_f = {1'b1, ~^b, b, 1'b0};
        f = '0;
        n = 0;
        while (!(ps2c_in && !ps2d_in) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rts_seen", 32'(n < 200), 1);
        repeat (4) @(negedge clk);
        f[0] = ps2d_in;
        check("start_bit", f[0], exp_f[0]);
        for (int k = 1; k <= edges; k++) begin
            dev_c = 1'b0;
            if (k == rst_fall) begin
                repeat (8) @(negedge clk);
                #2;
                check("d_oe_before_rst", ps2d_oe, 1);
                reset_n = 1'b0;
                #1;
                check("c_oe_async_rst", ps2c_oe, 0);
                check("d_oe_async_rst", ps2d_oe, 0);
                dev_c = 1'b1;
                return;
            end
            repeat (H) @(negedge clk);
            if (k <= 10) begin
                f[k] = ps2d_in;
                check($sformatf("bit%0d", k), f[k], exp_f[k]);
            end
            dev_c = 1'b1;
            if (k == 10 && ack_low) dev_d = 1'b0;
            if (k == 11) dev_d = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] b, input int edges, input bit ack_low,
                       input logic [10:0] exp_frame, input int exp_done, input int exp_err, input bit poke);
        int d0, e0;
        logic [10:0] f;
        d0 = n_done;
        e0 = n_err;
        send(b);
        fork
            device(b, edges, ack_low, 0, f);
            if (poke) begin
                repeat (100) @(negedge clk);
                tx_data = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_idle();
        repeat (40) @(negedge clk);
        check({tag, "_frame"}, 32'(f), 32'(exp_frame));
        check({tag, "_done"}, n_done - d0, exp_done);
        check({tag, "_err"}, n_err - e0, exp_err);
    endtask

    initial begin
        int n, d0, e0;
        reset_n = 1'b0;
        tx_start = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", {tx_busy, tx_done, tx_err, ps2c_oe, ps2d_oe}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run("ed", ps2_pkg::CMD_SET_LED, 11, 1'b1, 11'h7DA, 1, 0, 1'b0);
        run("f4", ps2_pkg::CMD_ENABLE, 11, 1'b1, 11'h5E8, 1, 0, 1'b0);
        run("nack", 8'h3C, 11, 1'b0, 11'h678, 0, 1, 1'b0);
        run("ff_poke", ps2_pkg::CMD_RESET, 11, 1'b1, 11'h7FE, 1, 0, 1'b1);
        d0 = n_done;
        e0 = n_err;
        send(ps2_pkg::CMD_RESET);
        n = 0;
        while (ps2c_oe && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("clk_release", ps2c_oe, 0);
        n = 0;
        while (!tx_err && n < T + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_cycles", n, T);
        check("timeout_pins", {ps2c_oe, ps2d_oe}, 0);
        @(posedge clk);
        #1;
        check("timeout_idle", tx_busy, 0);
        repeat (5) @(negedge clk);
        check("timeout_err", n_err - e0, 1);
        check("timeout_done", n_done - d0, 0);
        send(ps2_pkg::CMD_SET_LED);
        device(ps2_pkg::CMD_SET_LED, 11, 1'b1, 5, got);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run("ed_after_rst", ps2_pkg::CMD_SET_LED, 11, 1'b1, 11'h7DA, 1, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
